// File: rtl/shift_rot_pkg.sv
// Shared types and helpers for the rotate-register command sequencer.
//   state_t     : sequencer FSM states
//   amt_norm_t  : normalised rotate amount {dir_flip, count}
//   eff_amount  : folds a raw amount into a step count and optional direction flip
package shift_rot_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      ROT  = 3'd2,
      CAPT = 3'd3,
      RESP = 3'd4
   } state_t;

   typedef struct packed {
      logic        dir_flip;
      logic [31:0] count;
   } amt_norm_t;

   // Amounts at or above n wrap once; with shortest set, long rotations
   // become the complementary rotation in the opposite direction.
   function automatic amt_norm_t eff_amount(input int unsigned amt,
                                            input int unsigned n,
                                            input bit          shortest);
      int unsigned eff;
      amt_norm_t   res;
      eff          = (amt >= n) ? (amt - n) : amt;
      res.dir_flip = 1'b0;
      res.count    = eff;
      if (shortest && (eff > (n / 2))) begin
         res.dir_flip = 1'b1;
         res.count    = n - eff;
      end
      return res;
   endfunction

endpackage

// File: rtl/shift_rot_seq_norm.sv
// Combinational amount/direction normalisation at the command input.
// Ports:
//   amt      in  AW  raw rotate amount
//   right    in  1   requested direction (1 = right)
//   count_c  out CW  number of single-bit steps to issue
//   right_c  out 1   direction to actually rotate in
module rot_amt_norm
   import shift_rot_pkg::*;
#(
   parameter int unsigned N        = 8,
   parameter int unsigned AW       = $clog2(N),
   parameter int unsigned CW       = $clog2(N + 1),
   parameter int unsigned SHORTEST = 0
) (
   input  logic [AW-1:0] amt,
   input  logic          right,
   output logic [CW-1:0] count_c,
   output logic          right_c
);

   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CW) - 64'd1);

   amt_norm_t norm;

   // The clamp never engages for legal parameter sets; it keeps the
   // narrowing explicit if AW is ever widened beyond $clog2(N).
   always_comb begin
      norm    = eff_amount(32'(amt), N, SHORTEST != 0);
      count_c = (norm.count > CNT_MAX) ? CW'(CNT_MAX) : CW'(norm.count);
      right_c = right ^ norm.dir_flip;
   end

endmodule

// File: rtl/shift_rot_seq.sv
// Command sequencer for an N-bit left/right rotate register.
// Accepts {word, direction, amount}, loads the word into the register,
// issues the single-bit rotate steps, then returns the register contents.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_data/right/amt    word, direction (1 = right), rotate amount
//   reg_en/load/right     control to the rotate register
//   reg_data              load data to the rotate register
//   reg_q                 rotate register contents
//   rsp_valid/rsp_ready   response handshake
//   rsp_data              rotated word
//   busy                  high whenever not IDLE
module shift_rot_seq
   import shift_rot_pkg::*;
#(
   parameter int unsigned N        = 8,
   parameter int unsigned AW       = $clog2(N),
   parameter int unsigned SHORTEST = 0
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [N-1:0]  cmd_data,
   input  logic          cmd_right,
   input  logic [AW-1:0] cmd_amt,
   output logic          reg_en,
   output logic          reg_load,
   output logic          reg_right,
   output logic [N-1:0]  reg_data,
   input  logic [N-1:0]  reg_q,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [N-1:0]  rsp_data,
   output logic          busy
);

   localparam int unsigned CW = $clog2(N + 1);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic          dir;
   logic [CW-1:0] norm_count_c;
   logic          norm_right_c;
   logic          accept_c;

   logic          cmd_ready_nxt;
   logic          reg_en_nxt;
   logic          reg_load_nxt;
   logic          reg_right_nxt;
   logic [N-1:0]  reg_data_nxt;
   logic          rsp_valid_nxt;
   logic          busy_nxt;

   // Amount normalisation on the raw command fields.
   rot_amt_norm #(
      .N        (N),
      .AW       (AW),
      .CW       (CW),
      .SHORTEST (SHORTEST)
   ) u_norm (
      .amt     (cmd_amt),
      .right   (cmd_right),
      .count_c (norm_count_c),
      .right_c (norm_right_c)
   );

   // cmd_ready is only high in IDLE, so this also gates acceptance to IDLE.
   assign accept_c = cmd_valid && cmd_ready;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept_c)          state_nxt = LOAD;
         LOAD: state_nxt = (cnt != '0) ? ROT : CAPT;
         ROT:  if (cnt == CW'(1))     state_nxt = CAPT;
         CAPT: state_nxt = RESP;
         RESP: if (rsp_ready)         state_nxt = IDLE;
         default:                     state_nxt = IDLE;
      endcase
   end

   // Output decode from the upcoming state, so the registered outputs
   // line up with the state they belong to.
   always_comb begin
      cmd_ready_nxt = 1'b0;
      reg_en_nxt    = 1'b0;
      reg_load_nxt  = 1'b0;
      reg_right_nxt = 1'b0;
      reg_data_nxt  = '0;
      rsp_valid_nxt = 1'b0;
      busy_nxt      = 1'b1;
      case (state_nxt)
         IDLE: begin
            cmd_ready_nxt = 1'b1;
            busy_nxt      = 1'b0;
         end
         LOAD: begin
            // LOAD is only entered from IDLE on accept, so cmd_data is the captured word.
            reg_en_nxt   = 1'b1;
            reg_load_nxt = 1'b1;
            reg_data_nxt = cmd_data;
         end
         ROT: begin
            reg_en_nxt    = 1'b1;
            reg_right_nxt = dir;
         end
         CAPT: begin
         end
         RESP: begin
            rsp_valid_nxt = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_ready <= 1'b1;
         reg_en    <= 1'b0;
         reg_load  <= 1'b0;
         reg_right <= 1'b0;
         reg_data  <= '0;
         rsp_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         cmd_ready <= cmd_ready_nxt;
         reg_en    <= reg_en_nxt;
         reg_load  <= reg_load_nxt;
         reg_right <= reg_right_nxt;
         reg_data  <= reg_data_nxt;
         rsp_valid <= rsp_valid_nxt;
         busy      <= busy_nxt;
      end
   end

   // Step counter and captured direction.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         dir <= 1'b0;
      end else if (accept_c) begin
         cnt <= norm_count_c;
         dir <= norm_right_c;
      end else if (state == ROT) begin
         cnt <= cnt - CW'(1);
      end
   end

   // Result register: sampled after the last rotate step has landed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_data <= '0;
      end else if (state == CAPT) begin
         rsp_data <= reg_q;
      end
   end

endmodule
